sdram_rom_arbiter: RTL and testbench
====================================

# sdram_rom_arbiter

Shares the single SDRAM controller request port between the ROM-loading download path and up to four read requesters: 68000 program, Z80 sound, tile gfx and sprite gfx. During `rom_download`, bytes from the data_io channel are packed into 16-bit words and written with absolute priority. Otherwise, reads are granted round-robin with one transaction outstanding. The block sits between the core's fetch units and the SDRAM controller, inside the `prehisle` core.

## Interface
Parameters:
- `NREQ`, 4: number of read requesters.
- `AW`, 24: SDRAM word-address width.
- `DW`, 16: SDRAM data width.

Ports:
- `clk_sys` in 1: system clock, 72 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `rom_download` in 1: download in progress.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `rd_req` in NREQ: level request per requester; hold until ack.
- `rd_addr` in NREQ*AW: word address per requester; stable while `rd_req` is high.
- `rd_ack` out NREQ: one-cycle pulse per requester.
- `rd_data` out DW: shared read data, valid in the `rd_ack` cycle.
- `sd_req` out 1: request to the SDRAM controller, held until `sd_ack`.
- `sd_we` out 1: 1 = write.
- `sd_addr` out AW: SDRAM word address.
- `sd_din` out DW: write data.
- `sd_ack` in 1: one-cycle completion pulse from the controller.
- `sd_dout` in DW: read data, valid with `sd_ack`.
- `dl_overrun` out 1: sticky flag; a packed word was lost.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when a write is pending or a read is granted.
  - ISSUE drives `sd_req` = 1 → WAIT.
  - WAIT → DONE on `sd_ack`.
  - DONE → IDLE.
- Byte packing:
  - Even `ioctl_addr` byte is latched into `[15:8]`.
  - Odd byte goes to `[7:0]` and marks the word pending, with `sd_addr = ioctl_addr[24:1]`.
  - Write pending buffer depth is one word.
  - A new word completing while one is still pending sets `dl_overrun`; the new word is dropped.
- Download end: on the falling edge of `rom_download` with only an even byte latched, that word is flushed with `[7:0] = 0x00`.
- Priority: a pending write always wins over reads.
- Read gating: while `rom_download` is high, no read grant is issued. Requesters stay pending and receive no ack.
- Round-robin:
  - The grant goes to the first asserted `rd_req` strictly after `last_grant`, cyclic.
  - `last_grant` updates on grant.
  - Its reset value is NREQ-1, so requester 0 wins first.
- Read completion: on `sd_ack` for a read, `sd_dout` is registered into `rd_data` and `rd_ack[g]` pulses in DONE.
- Addresses: the granted `rd_addr` slice is registered at grant; later changes do not affect the transaction in flight.
- Write completion: `sd_ack` for a write clears the pending flag; no `rd_ack` is issued.
- `dl_overrun` is cleared only by reset.

## Timing
- Reset values: `rd_ack` = 0, `rd_data` = 0, `sd_req` = 0, `sd_we` = 0, `sd_addr` = 0, `sd_din` = 0, `dl_overrun` = 0, state = IDLE.
- Grant sampled in IDLE at cycle N → `sd_req` = 1 at N+1 → `sd_ack` at cycle M → `rd_ack`/`rd_data` at M+1, with `sd_req` already 0.
- Minimum turnaround is 4 cycles plus controller latency, back-to-back.
- `sd_req`, `sd_we`, `sd_addr` and `sd_din` are constant from ISSUE until `sd_ack`.
- An `sd_ack` arriving outside WAIT is ignored.
- `ioctl_wr` arriving in any state is packed in the same cycle; packing never stalls.
- A requester dropping `rd_req` mid-transaction still receives `rd_ack`.
- Asynchronous reset mid-transaction returns to IDLE with `sd_req` = 0. The SDRAM controller must tolerate an abandoned request.

## Structure
- Package `sdram_arb_pkg`:
  - `arb_state_t` enum (IDLE, ISSUE, WAIT, DONE).
  - Default constants for NREQ, AW and DW.
- Sub-module `rr_pick`: combinational round-robin picker with inputs `req[NREQ]` and `last[$clog2(NREQ)]`, outputs `grant_idx` and `valid`.
- Everything else stays in one always_ff FSM.

## Test plan
- Download bytes 0x12 @0 and 0x34 @1 → one write with `sd_addr` = 0, `sd_din` = 0x1234, `sd_we` = 1, and no `rd_ack`.
- `rd_req` = 0b1111 held, controller acks after 3 cycles → `rd_ack` order 0, 1, 2, 3, 0. Each `rd_data` equals its `sd_dout`.
- Download with `rd_req[2]` high → no read issued. The first read starts after the last write ack following `rom_download` falling.
- Three odd-byte completions with `sd_ack` withheld → `dl_overrun` = 1; only the first word is written.
- Download ends after an even byte 0xAB @0x10 → flush write with `sd_addr` = 8, `sd_din` = 0xAB00.
- `reset_n` low in WAIT → `sd_req` = 0 immediately. After release, the next `sd_ack` produces no `rd_ack`, and requester 0 is granted first.

Source files
------------

// File: rtl/sdram_rom_arbiter_pkg.sv
// Shared types and default sizes for the SDRAM port arbiter of the prehisle core.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 24;
  localparam int DW_DEF   = 16;

endpackage

// File: rtl/sdram_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after 'last', cyclic.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [LW-1:0]   grant_idx,
  output logic            valid
);

  logic [LW-1:0] idx;

  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = LW'((int'(last) + i) % NREQ);
      if (!valid && req[idx]) begin
        valid     = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/sdram_rom_arbiter.sv
// Shares one SDRAM request port between the ROM download writer (absolute priority)
// and NREQ round-robin read requesters, with one transaction outstanding.
module sdram_rom_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               rom_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic [NREQ-1:0]    rd_req,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic [NREQ-1:0]    rd_ack,
  output logic [DW-1:0]      rd_data,
  output logic               sd_req,
  output logic               sd_we,
  output logic [AW-1:0]      sd_addr,
  output logic [DW-1:0]      sd_din,
  input  logic               sd_ack,
  input  logic [DW-1:0]      sd_dout,
  output logic               dl_overrun,
  output logic [1:0]         dbg_state
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: sd_req rises in ISSUE and stays high with sd_we/sd_addr/sd_din frozen
  // until the single-cycle sd_ack in WAIT; sd_ack in any other state is ignored.
  arb_state_t state_q, state_d;

  logic [LW-1:0]   last_q, gnt_q, pick_idx;
  logic            pick_valid, rd_ok;
  logic            sd_req_q, sd_we_q;
  logic [AW-1:0]   sd_addr_q;
  logic [DW-1:0]   sd_din_q, rd_data_q;
  logic [NREQ-1:0] rd_ack_q;
  logic [7:0]      hi_q;
  logic            even_q, wr_pend_q, dl_q, ovr_q;
  logic [AW-1:0]   even_addr_q, wr_addr_q;
  logic [DW-1:0]   wr_data_q;

  rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
    .req       (rd_req),
    .last      (last_q),
    .grant_idx (pick_idx),
    .valid     (pick_valid)
  );

  // dl_q blocks reads for the cycle rom_download falls, so a tail flush wins over them.
  assign rd_ok = !rom_download && !dl_q && pick_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_pend_q || rd_ok) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (sd_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= LW'(NREQ - 1);
      gnt_q       <= '0;
      sd_req_q    <= 1'b0;
      sd_we_q     <= 1'b0;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
      rd_data_q   <= '0;
      rd_ack_q    <= '0;
      hi_q        <= '0;
      even_q      <= 1'b0;
      even_addr_q <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dl_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      dl_q     <= rom_download;
      rd_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (wr_pend_q) begin
            sd_req_q  <= 1'b1;
            sd_we_q   <= 1'b1;
            sd_addr_q <= wr_addr_q;
            sd_din_q  <= wr_data_q;
          end else if (rd_ok) begin
            sd_req_q  <= 1'b1;
            sd_we_q   <= 1'b0;
            sd_addr_q <= rd_addr[int'(pick_idx)*AW +: AW];
            gnt_q     <= pick_idx;
            last_q    <= pick_idx;
          end
        end
        WAIT: begin
          if (sd_ack) begin
            sd_req_q <= 1'b0;
            if (sd_we_q) begin
              wr_pend_q <= 1'b0;
            end else begin
              rd_data_q       <= sd_dout;
              rd_ack_q[gnt_q] <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Byte packing never stalls; a word completing while one is pending is dropped.
      if (rom_download && ioctl_wr) begin
        if (!ioctl_addr[0]) begin
          hi_q        <= ioctl_dout;
          even_q      <= 1'b1;
          even_addr_q <= AW'(ioctl_addr[24:1]);
        end else begin
          even_q <= 1'b0;
          if (wr_pend_q) begin
            ovr_q <= 1'b1;
          end else begin
            wr_pend_q <= 1'b1;
            wr_data_q <= DW'({hi_q, ioctl_dout});
            wr_addr_q <= AW'(ioctl_addr[24:1]);
          end
        end
      end else if (dl_q && !rom_download && even_q) begin
        even_q <= 1'b0;
        if (wr_pend_q) begin
          ovr_q <= 1'b1;
        end else begin
          wr_pend_q <= 1'b1;
          wr_data_q <= DW'({hi_q, 8'h00});
          wr_addr_q <= even_addr_q;
        end
      end
    end
  end

  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;
  assign sd_req     = sd_req_q;
  assign sd_we      = sd_we_q;
  assign sd_addr    = sd_addr_q;
  assign sd_din     = sd_din_q;
  assign dl_overrun = ovr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Directed bench for sdram_rom_arbiter: reset values, download packing/flush/overrun,
// round-robin read table, read gating during download and mid-transaction reset.
module tb_sdram_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 24;
  localparam int DW   = 16;

  logic               clk_sys = 1'b0;
  logic               reset_n = 1'b0;
  logic               rom_download = 1'b0;
  logic               ioctl_wr = 1'b0;
  logic [24:0]        ioctl_addr = '0;
  logic [7:0]         ioctl_dout = '0;
  logic [NREQ-1:0]    rd_req = '0;
  logic [NREQ*AW-1:0] rd_addr = '0;
  logic [NREQ-1:0]    rd_ack;
  logic [DW-1:0]      rd_data;
  logic               sd_req, sd_we;
  logic [AW-1:0]      sd_addr;
  logic [DW-1:0]      sd_din;
  logic               sd_ack = 1'b0;
  logic [DW-1:0]      sd_dout = '0;
  logic               dl_overrun;
  logic [1:0]         dbg_state;

  sdram_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .rom_download (rom_download),
    .ioctl_wr     (ioctl_wr),
    .ioctl_addr   (ioctl_addr),
    .ioctl_dout   (ioctl_dout),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data),
    .sd_req       (sd_req),
    .sd_we        (sd_we),
    .sd_addr      (sd_addr),
    .sd_din       (sd_din),
    .sd_ack       (sd_ack),
    .sd_dout      (sd_dout),
    .dl_overrun   (dl_overrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [NREQ*AW-1:0] base_addr;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [DW-1:0]   dout;
    logic [NREQ-1:0] exp_ack;
    logic [AW-1:0]   exp_addr;
  } rd_vec_t;

  rd_vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_rd(input string nm);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=0x%0h expected=empty_queue", nm, rd_data);
    end else begin
      e = exp_q.pop_front();
      check(nm, 32'(rd_data), 32'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_req(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_sys);
      if (sd_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s actual=no_sd_req expected=sd_req", nm);
    end
  endtask

  task automatic do_ack(input logic [DW-1:0] d, input int dly, input bit is_read);
    repeat (dly) tick();
    if (is_read) exp_q.push_back(d);
    sd_dout = d;
    sd_ack  = 1'b1;
    tick();
    sd_ack  = 1'b0;
    sd_dout = '0;
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < NREQ; i++) base_addr[i*AW +: AW] = 24'h0A0000 + AW'(i) * 24'h111;
    rd_addr = base_addr;

    vecs[0] = '{4'b1111, 16'h1001, 4'b0001, 24'h0A0000};
    vecs[1] = '{4'b1111, 16'h2002, 4'b0010, 24'h0A0111};
    vecs[2] = '{4'b1111, 16'h3003, 4'b0100, 24'h0A0222};
    vecs[3] = '{4'b1111, 16'h4004, 4'b1000, 24'h0A0333};
    vecs[4] = '{4'b1111, 16'h5005, 4'b0001, 24'h0A0000};
    vecs[5] = '{4'b0100, 16'hA55A, 4'b0100, 24'h0A0222};
    vecs[6] = '{4'b1001, 16'hBEEF, 4'b1000, 24'h0A0333};
    vecs[7] = '{4'b1001, 16'hCAFE, 4'b0001, 24'h0A0000};
    vecs[8] = '{4'b0010, 16'h0F0F, 4'b0010, 24'h0A0111};
    vecs[9] = '{4'b0011, 16'hFFFF, 4'b0001, 24'h0A0000};

    // Reset values
    repeat (3) @(negedge clk_sys);
    check("rst_rd_ack", 32'(rd_ack), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_sd_req", 32'(sd_req), 0);
    check("rst_sd_we", 32'(sd_we), 0);
    check("rst_sd_addr", 32'(sd_addr), 0);
    check("rst_sd_din", 32'(sd_din), 0);
    check("rst_overrun", 32'(dl_overrun), 0);
    check("rst_state", 32'(dbg_state), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Download 0x12@0, 0x34@1 -> one write of 0x1234 to word 0
    rom_download = 1'b1;
    tick();
    dl_byte(25'd0, 8'h12);
    dl_byte(25'd1, 8'h34);
    wait_req("a_req");
    check("a_we", 32'(sd_we), 1);
    check("a_addr", 32'(sd_addr), 0);
    check("a_din", 32'(sd_din), 32'h1234);
    tick();
    do_ack(16'hDEAD, 2, 1'b0);
    @(negedge clk_sys);
    check("a_no_rd_ack", 32'(rd_ack), 0);
    check("a_rd_data_kept", 32'(rd_data), 0);
    tick();
    rom_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("a_no_extra", 32'(sd_req), 0);
    tick();

    // Round-robin read table, rd_addr changed while the read is in flight
    for (int v = 0; v < 10; v++) begin
      rd_addr = base_addr;
      rd_req  = vecs[v].mask;
      wait_req($sformatf("rr%0d_req", v));
      check($sformatf("rr%0d_we", v), 32'(sd_we), 0);
      check($sformatf("rr%0d_addr", v), 32'(sd_addr), 32'(vecs[v].exp_addr));
      tick();
      rd_addr = ~base_addr;
      @(negedge clk_sys);
      check($sformatf("rr%0d_addr_hold", v), 32'(sd_addr), 32'(vecs[v].exp_addr));
      tick();
      do_ack(vecs[v].dout, 1, 1'b1);
      @(negedge clk_sys);
      check($sformatf("rr%0d_ack", v), 32'(rd_ack), 32'(vecs[v].exp_ack));
      check($sformatf("rr%0d_req_low", v), 32'(sd_req), 0);
      check_rd($sformatf("rr%0d_data", v));
      tick();
    end
    rd_req  = '0;
    rd_addr = base_addr;

    // Reads gated during download; tail even byte flushed before the pending read
    rom_download = 1'b1;
    rd_req = 4'b0100;
    tick();
    dl_byte(25'h10, 8'hAB);
    repeat (4) tick();
    @(negedge clk_sys);
    check("c_no_read_in_dl", 32'(sd_req), 0);
    check("c_no_ack_in_dl", 32'(rd_ack), 0);
    tick();
    rom_download = 1'b0;
    wait_req("c_flush_req");
    check("c_flush_we", 32'(sd_we), 1);
    check("c_flush_addr", 32'(sd_addr), 8);
    check("c_flush_din", 32'(sd_din), 32'hAB00);
    tick();
    do_ack(16'h0000, 1, 1'b0);
    @(negedge clk_sys);
    check("c_flush_no_ack", 32'(rd_ack), 0);
    tick();
    wait_req("c_read_req");
    check("c_read_we", 32'(sd_we), 0);
    check("c_read_addr", 32'(sd_addr), 32'h0A0222);
    tick();
    do_ack(16'h5A5A, 1, 1'b1);
    @(negedge clk_sys);
    check("c_read_ack", 32'(rd_ack), 32'b0100);
    check_rd("c_read_data");
    tick();
    rd_req = '0;

    // Overrun: three words complete while the first write waits for its ack
    rom_download = 1'b1;
    tick();
    dl_byte(25'h20, 8'h11);
    dl_byte(25'h21, 8'h22);
    dl_byte(25'h22, 8'h33);
    dl_byte(25'h23, 8'h44);
    dl_byte(25'h24, 8'h55);
    dl_byte(25'h25, 8'h66);
    @(negedge clk_sys);
    check("d_overrun", 32'(dl_overrun), 1);
    check("d_state_wait", 32'(dbg_state), 2);
    check("d_req_held", 32'(sd_req), 1);
    check("d_addr", 32'(sd_addr), 32'h10);
    check("d_din", 32'(sd_din), 32'h1122);
    tick();
    do_ack(16'h0000, 0, 1'b0);
    @(negedge clk_sys);
    check("d_no_rd_ack", 32'(rd_ack), 0);
    tick();
    rom_download = 1'b0;
    repeat (6) tick();
    @(negedge clk_sys);
    check("d_dropped", 32'(sd_req), 0);
    check("d_overrun_sticky", 32'(dl_overrun), 1);
    tick();

    // Reset while in WAIT, then a stray ack, then requester 0 wins first
    rd_req = 4'b0001;
    wait_req("e_req");
    tick();
    @(negedge clk_sys);
    check("e_in_wait", 32'(dbg_state), 2);
    #2;
    reset_n = 1'b0;
    rd_req  = '0;
    #1;
    check("e_async_req", 32'(sd_req), 0);
    check("e_async_state", 32'(dbg_state), 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    check("e_overrun_cleared", 32'(dl_overrun), 0);
    tick();
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    @(negedge clk_sys);
    check("e_stray_no_ack", 32'(rd_ack), 0);
    check("e_stray_no_req", 32'(sd_req), 0);
    tick();
    rd_req = 4'b1111;
    wait_req("e_first_req");
    check("e_first_addr", 32'(sd_addr), 32'h0A0000);
    tick();
    do_ack(16'h7777, 1, 1'b1);
    @(negedge clk_sys);
    check("e_first_ack", 32'(rd_ack), 32'b0001);
    check_rd("e_first_data");
    tick();
    rd_req = '0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
